// File: rtl/pic_priority_resolver.sv
// Request/in-service stage of an 8259-style interrupt controller: captures IR lines,
// masks them, resolves rotating fully-nested priority and tracks the in-service levels.
module pic_priority_resolver #(
  parameter int NUM_IR       = 8,
  parameter int RESET_LOWEST = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir_in,
  input  logic       ltim,
  input  logic [7:0] imr,
  input  logic       ack_first,
  input  logic       ack_second,
  input  logic       aeoi,
  input  logic       eoi,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       eoi_rotate,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic       int_req,
  output logic [2:0] ack_level,
  output logic       spurious
);

  logic [7:0] ir_prev_q, ir_prev_d;
  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [2:0] lowest_q, lowest_d;
  logic       int_req_q, int_req_d;
  logic [2:0] ack_level_q, ack_level_d;
  logic       spurious_q, spurious_d;
  logic       ack_pend_q, ack_pend_d;

  // Returns {found, level} of the highest-priority set bit, priority starting at low+1.
  function automatic logic [3:0] pick(input logic [7:0] v, input logic [2:0] low);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'd0;
    for (int k = NUM_IR - 1; k >= 0; k--) begin
      idx = 3'(low + 3'd1 + 3'(k));
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  logic [3:0] cand, isr_top;
  logic [2:0] cand_prio, isr_prio;
  logic       cand_valid;
  logic [7:0] isr_set, isr_clr, irr_ack_clr;

  always_comb begin
    cand       = pick(irr_q & ~imr, lowest_q);
    isr_top    = pick(isr_q, lowest_q);
    cand_prio  = 3'(cand[2:0] - lowest_q - 3'd1);
    isr_prio   = 3'(isr_top[2:0] - lowest_q - 3'd1);
    cand_valid = cand[3] && (!isr_top[3] || (cand_prio < isr_prio));
  end

  always_comb begin
    ir_prev_d   = ir_in;
    int_req_d   = cand_valid;
    ack_level_d = ack_level_q;
    spurious_d  = 1'b0;
    ack_pend_d  = ack_pend_q;
    lowest_d    = lowest_q;
    isr_set     = 8'h00;
    isr_clr     = 8'h00;
    irr_ack_clr = 8'h00;

    if (ack_first) begin
      if (cand_valid) begin
        ack_level_d          = cand[2:0];
        isr_set[cand[2:0]]   = 1'b1;
        irr_ack_clr          = isr_set;
        ack_pend_d           = 1'b1;
      end else begin
        ack_level_d = 3'd7;
        spurious_d  = 1'b1;
        ack_pend_d  = 1'b0;
      end
    end else if (ack_second) begin
      ack_pend_d = 1'b0;
    end

    // Automatic EOI only closes a sequence that a real ack_first opened.
    if (ack_second && aeoi && ack_pend_q) begin
      isr_clr[ack_level_q] = 1'b1;
      if (eoi_rotate) lowest_d = ack_level_q;
    end

    if (eoi) begin
      if (eoi_specific) begin
        isr_clr[eoi_level] = 1'b1;
        if (eoi_rotate) lowest_d = eoi_level;
      end else if (isr_top[3]) begin
        isr_clr[isr_top[2:0]] = 1'b1;
        if (eoi_rotate) lowest_d = isr_top[2:0];
      end
    end

    isr_d = (isr_q & ~isr_clr) | isr_set;

    if (ltim) irr_d = ir_in;
    else      irr_d = (irr_q & ~(~ir_in | irr_ack_clr)) | (ir_in & ~ir_prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_prev_q   <= 8'h00;
      irr_q       <= 8'h00;
      isr_q       <= 8'h00;
      lowest_q    <= 3'(RESET_LOWEST);
      int_req_q   <= 1'b0;
      ack_level_q <= 3'd7;
      spurious_q  <= 1'b0;
      ack_pend_q  <= 1'b0;
    end else begin
      ir_prev_q   <= ir_prev_d;
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      lowest_q    <= lowest_d;
      int_req_q   <= int_req_d;
      ack_level_q <= ack_level_d;
      spurious_q  <= spurious_d;
      ack_pend_q  <= ack_pend_d;
    end
  end

  assign irr       = irr_q;
  assign isr       = isr_q;
  assign int_req   = int_req_q;
  assign ack_level = ack_level_q;
  assign spurious  = spurious_q;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed bench for pic_priority_resolver; one task per scenario with inline checks.
module tb_pic_priority_resolver;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ir_in, imr;
  logic       ltim, ack_first, ack_second, aeoi, eoi, eoi_specific, eoi_rotate;
  logic [2:0] eoi_level;
  logic [7:0] irr, isr;
  logic       int_req, spurious;
  logic [2:0] ack_level;
  int total = 0;
  int bad = 0;

  pic_priority_resolver dut (
    .clk(clk), .rst(rst), .ir_in(ir_in), .ltim(ltim), .imr(imr),
    .ack_first(ack_first), .ack_second(ack_second), .aeoi(aeoi), .eoi(eoi),
    .eoi_specific(eoi_specific), .eoi_level(eoi_level), .eoi_rotate(eoi_rotate),
    .irr(irr), .isr(isr), .int_req(int_req), .ack_level(ack_level), .spurious(spurious)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    ir_in = 0; imr = 0; ltim = 0; ack_first = 0; ack_second = 0; aeoi = 0;
    eoi = 0; eoi_specific = 0; eoi_level = 0; eoi_rotate = 0;
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (irr !== 8'h00) begin bad++; $display("FAIL reset_irr got=%h exp=00", irr); end
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL reset_isr got=%h exp=00", isr); end
    total++; if (int_req !== 1'b0 || spurious !== 1'b0) begin bad++;
      $display("FAIL reset_flags got int_req=%b spurious=%b exp=0 0", int_req, spurious); end
    total++; if (ack_level !== 3'd7) begin bad++; $display("FAIL reset_ack_level got=%0d exp=7", ack_level); end
  endtask

  task automatic test_basic();
    do_reset();
    ir_in = 8'h04; tick();
    total++; if (irr !== 8'h04 || int_req !== 1'b0) begin bad++;
      $display("FAIL basic_irr got irr=%h int_req=%b exp=04 0", irr, int_req); end
    tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL basic_int_req got=%b exp=1", int_req); end
    ack_first = 1; tick(); ack_first = 0;
    total++; if (ack_level !== 3'd2 || isr !== 8'h04 || irr !== 8'h00) begin bad++;
      $display("FAIL basic_ack got lvl=%0d isr=%h irr=%h exp=2 04 00", ack_level, isr, irr); end
    ir_in = 0; eoi = 1; tick(); eoi = 0;
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL basic_eoi got isr=%h exp=00", isr); end
  endtask

  task automatic test_nesting();
    do_reset();
    ir_in = 8'h88; tick(); tick();
    ack_first = 1; tick(); ack_first = 0;
    total++; if (ack_level !== 3'd3 || isr !== 8'h08 || irr !== 8'h80) begin bad++;
      $display("FAIL nest_ack got lvl=%0d isr=%h irr=%h exp=3 08 80", ack_level, isr, irr); end
    tick(); tick();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL nest_blocked got=%b exp=0", int_req); end
    ir_in = 8'h8A; tick(); tick();
    total++; if (int_req !== 1'b1 || irr !== 8'h82) begin bad++;
      $display("FAIL nest_ir1 got int_req=%b irr=%h exp=1 82", int_req, irr); end
  endtask

  task automatic test_mask();
    do_reset();
    imr = 8'h08; ir_in = 8'h08; tick();
    total++; if (irr !== 8'h08) begin bad++; $display("FAIL mask_irr got=%h exp=08", irr); end
    tick(); tick();
    total++; if (int_req !== 1'b0) begin bad++; $display("FAIL mask_blocked got=%b exp=0", int_req); end
    imr = 8'h00; tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL mask_release got=%b exp=1", int_req); end
  endtask

  task automatic test_rotate();
    do_reset();
    ir_in = 8'h10; tick(); tick();
    ack_first = 1; tick(); ack_first = 0;
    total++; if (isr !== 8'h10) begin bad++; $display("FAIL rot_isr got=%h exp=10", isr); end
    ir_in = 0; eoi = 1; eoi_rotate = 1; tick(); eoi = 0; eoi_rotate = 0;
    total++; if (isr !== 8'h00) begin bad++; $display("FAIL rot_eoi got isr=%h exp=00", isr); end
    ir_in = 8'h21; tick(); tick();
    ack_first = 1; tick(); ack_first = 0;
    total++; if (ack_level !== 3'd5 || irr !== 8'h01) begin bad++;
      $display("FAIL rot_winner got lvl=%0d irr=%h exp=5 01", ack_level, irr); end
  endtask

  task automatic test_specific_rotate();
    do_reset();
    eoi = 1; eoi_specific = 1; eoi_level = 3'd2; eoi_rotate = 1; tick();
    eoi = 0; eoi_specific = 0; eoi_rotate = 0;
    ir_in = 8'h09; tick(); tick();
    ack_first = 1; tick(); ack_first = 0;
    total++; if (ack_level !== 3'd3 || isr !== 8'h08) begin bad++;
      $display("FAIL spec_rot got lvl=%0d isr=%h exp=3 08", ack_level, isr); end
  endtask

  task automatic test_aeoi_level();
    do_reset();
    ltim = 1; aeoi = 1; ir_in = 8'h40; tick(); tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL aeoi_req got=%b exp=1", int_req); end
    ack_first = 1; tick(); ack_first = 0;
    total++; if (isr !== 8'h40 || irr !== 8'h40 || ack_level !== 3'd6) begin bad++;
      $display("FAIL aeoi_ack got isr=%h irr=%h lvl=%0d exp=40 40 6", isr, irr, ack_level); end
    ack_second = 1; tick(); ack_second = 0;
    total++; if (isr !== 8'h00 || irr !== 8'h40) begin bad++;
      $display("FAIL aeoi_second got isr=%h irr=%h exp=00 40", isr, irr); end
    tick();
    total++; if (int_req !== 1'b1) begin bad++; $display("FAIL aeoi_rereq got=%b exp=1", int_req); end
  endtask

  task automatic test_spurious_and_reset();
    do_reset();
    ir_in = 8'h01; tick(); ir_in = 8'h00; tick();
    total++; if (irr !== 8'h00) begin bad++; $display("FAIL spur_irr got=%h exp=00", irr); end
    ack_first = 1; tick(); ack_first = 0;
    total++; if (spurious !== 1'b1 || ack_level !== 3'd7 || isr !== 8'h00) begin bad++;
      $display("FAIL spur_ack got sp=%b lvl=%0d isr=%h exp=1 7 00", spurious, ack_level, isr); end
    tick();
    total++; if (spurious !== 1'b0) begin bad++; $display("FAIL spur_pulse got=%b exp=0", spurious); end
    ir_in = 8'h02; tick(); tick();
    ack_first = 1; tick(); ack_first = 0;
    total++; if (ack_level !== 3'd1 || isr !== 8'h02) begin bad++;
      $display("FAIL rst_mid_ack got lvl=%0d isr=%h exp=1 02", ack_level, isr); end
    ir_in = 8'h00; rst = 1; tick(); rst = 0;
    total++; if (isr !== 8'h00 || irr !== 8'h00 || int_req !== 1'b0 || ack_level !== 3'd7) begin bad++;
      $display("FAIL rst_mid_state got isr=%h irr=%h req=%b lvl=%0d exp=00 00 0 7", isr, irr, int_req, ack_level); end
    aeoi = 1; eoi_rotate = 1; ack_second = 1; tick(); ack_second = 0; eoi_rotate = 0;
    ir_in = 8'h81; tick(); tick();
    ack_first = 1; tick(); ack_first = 0;
    total++; if (ack_level !== 3'd0 || isr !== 8'h01) begin bad++;
      $display("FAIL rst_ack2_ignored got lvl=%0d isr=%h exp=0 01", ack_level, isr); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nesting();
    test_mask();
    test_rotate();
    test_specific_rotate();
    test_aeoi_level();
    test_spurious_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pic_priority_resolver.md
Name: pic_priority_resolver

Overview:
- Interrupt request/in-service stage of the 8259-style interrupt controller; sits directly upstream of the control logic.
- Captures the IR0..IR7 lines into the IRR, applies the mask, and resolves priority with fully nested mode and rotation.
- Tracks in-service levels in the ISR and drives the request and the acknowledged level consumed by the control logic during the INTA sequence.

Parameters:
- NUM_IR, 8, number of interrupt lines. Fixed at 8; the level encoding is 3 bits wide.
- RESET_LOWEST, 7, reset value of the lowest-priority pointer, so IR0 is highest after reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ir_in  input  8  raw interrupt request lines IR7..IR0.
- ltim  input  1  trigger mode: 1 = level triggered, 0 = rising-edge triggered.
- imr  input  8  interrupt mask; 1 = masked.
- ack_first  input  1  one-cycle strobe on the first INTA from the control logic.
- ack_second  input  1  one-cycle strobe on the second INTA from the control logic.
- aeoi  input  1  automatic EOI enabled.
- eoi  input  1  one-cycle end-of-interrupt command strobe.
- eoi_specific  input  1  qualifies eoi: 1 = specific, 0 = non-specific.
- eoi_level  input  3  target level for a specific EOI.
- eoi_rotate  input  1  qualifies eoi: rotate priority on EOI.
- irr  output  8  interrupt request register.
- isr  output  8  in-service register.
- int_req  output  1  request to the control logic.
- ack_level  output  3  level latched at ack_first, used to build the vector.
- spurious  output  1  one-cycle pulse when ack_first finds no valid request.

Behaviour:
- Reset (rst=1 at a clock edge): irr=0, isr=0, int_req=0, ack_level=7, spurious=0, lowest pointer=RESET_LOWEST, ir_prev=0. Reset overrides every strobe in the same cycle. Reset during an INTA sequence abandons it; a following ack_second has no effect.
- ir_prev: registers ir_in every cycle.
- Edge mode (ltim=0):
  - irr[i] is set on the cycle after ir_in[i]=1 while ir_prev[i]=0.
  - irr[i] is cleared when ir_in[i]=0, or by ack_first selecting level i.
  - If set and clear occur in the same cycle, set wins.
- Level mode (ltim=1): irr = ir_in registered; ack_first does not clear it.
- Priority order: starts at (lowest+1) mod 8 and wraps through lowest.
  - Candidate = highest-priority bit of (irr & ~imr).
  - Valid only if strictly higher priority than the highest set isr bit, or isr=0.
  - Masked bits never win. Masking does not affect isr.
- int_req: registered; 1 when a valid candidate exists. Latency from an edge on ir_in to int_req is 2 clocks. Drops the cycle after the candidate is consumed or masked.
- ack_first:
  - Valid candidate: ack_level := candidate, isr[candidate] := 1, irr clear as above.
  - No valid candidate: ack_level := 7, isr unchanged, spurious=1 for one cycle.
- ack_second with aeoi=1: clears isr[ack_level]. If eoi_rotate=1 in the same cycle, lowest := ack_level. Ignored after a spurious ack.
- Non-specific eoi: clears the highest-priority set isr bit. With eoi_rotate=1, lowest := that level. No effect if isr=0.
- Specific eoi: clears isr[eoi_level]. With eoi_rotate=1, lowest := eoi_level, even if the bit was already clear.
- eoi in the same cycle as ack_first: the EOI is evaluated on the pre-cycle isr and pointer. ack_first's selection also uses the pre-cycle state. Both updates then apply; a set from ack_first wins over a clear of the same bit.
- The lowest-priority pointer wraps modulo 8.

Test Plan:
1. Reset; pulse ir_in=8'h04 (edge mode), imr=0 -> irr=8'h04 after 1 clk, int_req=1 after 2 clk. ack_first -> ack_level=2, isr=8'h04, irr=0. Non-specific eoi -> isr=0.
2. ir_in=8'h88 simultaneously -> ack_level=3. While IR3 is in service, IR7 stays pending with int_req=0. Raising IR1 -> int_req=1 (nesting).
3. imr=8'h08, ir_in=8'h08 -> irr=8'h08, int_req stays 0. Then imr=0 -> int_req=1 within 1 clk.
4. Rotation: isr=8'h10, eoi with eoi_rotate=1 non-specific -> lowest=4. Then ir_in=8'h21 -> ack_level=5 wins over IR0.
5. aeoi=1 level mode, ir_in=8'h40 held -> ack_first sets isr=8'h40, ack_second clears it, irr stays 8'h40, int_req reasserts.
6. Edge request dropped before ack: ir_in 0->1->0, then ack_first -> spurious=1, ack_level=7, isr=0. Also assert rst between ack_first and ack_second -> all outputs at reset values and ack_second ignored.
